// File: rtl/block_pkg.sv
// Shared constants, direction codes and pass-through payload for the block geometry pipeline.
package block_pkg;

    localparam int unsigned NUM_BLOCKS = 12;
    localparam int unsigned TIME_W     = 18;
    localparam int unsigned XY_W       = 12;
    localparam int unsigned Z_W        = 14;
    localparam int unsigned DIR_W      = 3;
    localparam int unsigned SPEED      = 4;
    localparam int unsigned Z_FAR      = 16000;
    localparam int unsigned Z_MAX      = (2 ** Z_W) - 1;
    // Wide enough for the largest diff times SPEED without overflow
    localparam int unsigned PROD_W     = TIME_W + 3;

    typedef enum logic [DIR_W-1:0] {
        DIR_UP         = 3'd0,
        DIR_DOWN       = 3'd1,
        DIR_LEFT       = 3'd2,
        DIR_RIGHT      = 3'd3,
        DIR_UP_LEFT    = 3'd4,
        DIR_UP_RIGHT   = 3'd5,
        DIR_DOWN_LEFT  = 3'd6,
        DIR_DOWN_RIGHT = 3'd7
    } block_dir_e;

    typedef struct packed {
        logic [XY_W-1:0]  x;
        logic [XY_W-1:0]  y;
        logic             color;
        logic [DIR_W-1:0] dir;
    } block_attr_t;

endpackage

// File: rtl/block_depth_calc.sv
// One slot's two-stage depth pipeline: time difference, scale, saturate, visibility.
// Optional visibility mask input when BLOCK_VISIBLE_MASK_EN is defined.
module block_depth_calc
    import block_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [TIME_W-1:0] curr_time,
    input  logic [TIME_W-1:0] block_time,
`ifdef BLOCK_VISIBLE_MASK_EN
    input  logic              visible_mask,
`endif
    output logic [Z_W-1:0]    z,
    output logic              visible
);

    logic [TIME_W-1:0] diff_q;
    logic              late_q;
    logic [PROD_W-1:0] prod_c;
    logic [Z_W-1:0]    z_c;
    logic              vis_c;
`ifdef BLOCK_VISIBLE_MASK_EN
    logic              mask_q;
`endif

    // Stage 1: signed-free difference plus a separate "already passed" flag
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            diff_q <= '0;
            late_q <= 1'b0;
        end else begin
            diff_q <= block_time - curr_time;
            late_q <= (curr_time > block_time);
        end
    end

`ifdef BLOCK_VISIBLE_MASK_EN
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) mask_q <= 1'b0;
        else         mask_q <= visible_mask;
    end
`endif

    always_comb begin
        prod_c = PROD_W'(diff_q) * PROD_W'(SPEED);
        z_c    = '0;
        if (!late_q) z_c = (prod_c > PROD_W'(Z_MAX)) ? '1 : Z_W'(prod_c);
        vis_c  = !late_q && (prod_c <= PROD_W'(Z_FAR));
`ifdef BLOCK_VISIBLE_MASK_EN
        vis_c  = vis_c && mask_q;
`endif
    end

    // Stage 2: registered results
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            z       <= '0;
            visible <= 1'b0;
        end else begin
            z       <= z_c;
            visible <= vis_c;
        end
    end

endmodule

// File: rtl/block_positions.sv
// Per-frame depth/visibility stage for the block table; attributes delayed to stay aligned.
// Define BLOCK_VISIBLE_MASK_EN to add the block_visible_in mask port.
module block_positions
    import block_pkg::*;
(
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic [TIME_W-1:0]                   curr_time_in,
    input  logic [NUM_BLOCKS-1:0][XY_W-1:0]     block_x_in,
    input  logic [NUM_BLOCKS-1:0][XY_W-1:0]     block_y_in,
    input  logic [NUM_BLOCKS-1:0][TIME_W-1:0]   block_time_in,
    input  logic [NUM_BLOCKS-1:0]               block_color_in,
    input  logic [NUM_BLOCKS-1:0][DIR_W-1:0]    block_direction_in,
`ifdef BLOCK_VISIBLE_MASK_EN
    input  logic [NUM_BLOCKS-1:0]               block_visible_in,
`endif
    output logic [TIME_W-1:0]                   curr_time_out,
    output logic [NUM_BLOCKS-1:0][XY_W-1:0]     block_x_out,
    output logic [NUM_BLOCKS-1:0][XY_W-1:0]     block_y_out,
    output logic [NUM_BLOCKS-1:0][Z_W-1:0]      block_z_out,
    output logic [NUM_BLOCKS-1:0]               block_color_out,
    output logic [NUM_BLOCKS-1:0][DIR_W-1:0]    block_direction_out,
    output logic [NUM_BLOCKS-1:0]               block_visible_out
);

    block_attr_t [NUM_BLOCKS-1:0] attr_c;
    block_attr_t [NUM_BLOCKS-1:0] attr_q1;
    block_attr_t [NUM_BLOCKS-1:0] attr_q2;
    logic [TIME_W-1:0]            time_q1;

    for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_slot
        assign attr_c[i] = '{x:     block_x_in[i],
                             y:     block_y_in[i],
                             color: block_color_in[i],
                             dir:   block_direction_in[i]};

        block_depth_calc u_depth (
            .clk_in       (clk_in),
            .rst_in       (rst_in),
            .curr_time    (curr_time_in),
            .block_time   (block_time_in[i]),
`ifdef BLOCK_VISIBLE_MASK_EN
            .visible_mask (block_visible_in[i]),
`endif
            .z            (block_z_out[i]),
            .visible      (block_visible_out[i])
        );

        assign block_x_out[i]         = attr_q2[i].x;
        assign block_y_out[i]         = attr_q2[i].y;
        assign block_color_out[i]     = attr_q2[i].color;
        assign block_direction_out[i] = attr_q2[i].dir;
    end

    // Two-deep delay line matching the depth pipeline latency
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            attr_q1       <= '0;
            attr_q2       <= '0;
            time_q1       <= '0;
            curr_time_out <= '0;
        end else begin
            attr_q1       <= attr_c;
            attr_q2       <= attr_q1;
            time_q1       <= curr_time_in;
            curr_time_out <= time_q1;
        end
    end

endmodule

// File: tb/tb_block_positions.sv
// Self-checking bench for block_positions: directed boundaries plus randomized vectors vs a rule model.
module tb_block_positions;
    import block_pkg::*;

    localparam int unsigned N = NUM_BLOCKS;

    logic                          clk_in = 1'b0;
    logic                          rst_in = 1'b0;
    logic [TIME_W-1:0]             curr_time_in;
    logic [N-1:0][XY_W-1:0]        block_x_in, block_y_in;
    logic [N-1:0][TIME_W-1:0]      block_time_in;
    logic [N-1:0]                  block_color_in;
    logic [N-1:0][DIR_W-1:0]       block_direction_in;
    logic [N-1:0]                  block_visible_in;
    logic [TIME_W-1:0]             curr_time_out;
    logic [N-1:0][XY_W-1:0]        block_x_out, block_y_out;
    logic [N-1:0][Z_W-1:0]         block_z_out;
    logic [N-1:0]                  block_color_out;
    logic [N-1:0][DIR_W-1:0]       block_direction_out;
    logic [N-1:0]                  block_visible_out;

    always #5 clk_in = ~clk_in;

    block_positions dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .curr_time_in        (curr_time_in),
        .block_x_in          (block_x_in),
        .block_y_in          (block_y_in),
        .block_time_in       (block_time_in),
        .block_color_in      (block_color_in),
        .block_direction_in  (block_direction_in),
`ifdef BLOCK_VISIBLE_MASK_EN
        .block_visible_in    (block_visible_in),
`endif
        .curr_time_out       (curr_time_out),
        .block_x_out         (block_x_out),
        .block_y_out         (block_y_out),
        .block_z_out         (block_z_out),
        .block_color_out     (block_color_out),
        .block_direction_out (block_direction_out),
        .block_visible_out   (block_visible_out)
    );

    typedef struct {
        logic [TIME_W-1:0]        t;
        logic [N-1:0][XY_W-1:0]   x;
        logic [N-1:0][XY_W-1:0]   y;
        logic [N-1:0][TIME_W-1:0] bt;
        logic [N-1:0]             c;
        logic [N-1:0][DIR_W-1:0]  d;
        logic [N-1:0]             m;
    } vec_t;

    vec_t pend[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, idx, obs, exp);
        end
    endtask

    // Reference: depth = (hit time - now) * SPEED, clamped; passed blocks sit at 0 and hide
    function automatic int exp_z(input vec_t v, input int i);
        int p;
        if (int'(v.t) > int'(v.bt[i])) return 0;
        p = (int'(v.bt[i]) - int'(v.t)) * int'(SPEED);
        return (p > 16383) ? 16383 : p;
    endfunction

    function automatic int exp_vis(input vec_t v, input int i);
        int p;
        if (int'(v.t) > int'(v.bt[i])) return 0;
        p = (int'(v.bt[i]) - int'(v.t)) * int'(SPEED);
`ifdef BLOCK_VISIBLE_MASK_EN
        if (v.m[i] == 1'b0) return 0;
`endif
        return (p <= 16000) ? 1 : 0;
    endfunction

    task automatic check_vec(input vec_t v);
        chk("curr_time_out", 0, 32'(curr_time_out), 32'(v.t));
        for (int i = 0; i < int'(N); i++) begin
            chk("z",   i, 32'(block_z_out[i]), 32'(exp_z(v, i)));
            chk("vis", i, 32'(block_visible_out[i]), 32'(exp_vis(v, i)));
            chk("x",   i, 32'(block_x_out[i]), 32'(v.x[i]));
            chk("y",   i, 32'(block_y_out[i]), 32'(v.y[i]));
            chk("col", i, 32'(block_color_out[i]), 32'(v.c[i]));
            chk("dir", i, 32'(block_direction_out[i]), 32'(v.d[i]));
        end
    endtask

    // Drive one vector for one cycle; check the vector issued two edges earlier
    task automatic step(input vec_t v);
        curr_time_in       = v.t;
        block_x_in         = v.x;
        block_y_in         = v.y;
        block_time_in      = v.bt;
        block_color_in     = v.c;
        block_direction_in = v.d;
        block_visible_in   = v.m;
        pend.push_back(v);
        @(posedge clk_in);
        #1;
        if (pend.size() == 2) begin
            check_vec(pend[0]);
            void'(pend.pop_front());
        end
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        v.t = TIME_W'($urandom_range(0, 262143));
        for (int i = 0; i < int'(N); i++) begin
            v.x[i]  = XY_W'($urandom);
            v.y[i]  = XY_W'($urandom);
            v.bt[i] = TIME_W'(v.t + TIME_W'($urandom_range(0, 4200)) - TIME_W'(60));
            v.c[i]  = 1'($urandom);
            v.d[i]  = DIR_W'($urandom);
            v.m[i]  = 1'($urandom_range(0, 3) != 0);
        end
        return v;
    endfunction

    function automatic vec_t base_vec();
        vec_t v;
        v = rand_vec();
        v.t  = '0;
        v.bt = '1;
        v.m  = '1;
        return v;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_time"}, 0, 32'(curr_time_out), 32'd0);
        for (int i = 0; i < int'(N); i++) begin
            chk({tag, "_z"},   i, 32'(block_z_out[i]), 32'd0);
            chk({tag, "_vis"}, i, 32'(block_visible_out[i]), 32'd0);
            chk({tag, "_x"},   i, 32'(block_x_out[i]), 32'd0);
            chk({tag, "_y"},   i, 32'(block_y_out[i]), 32'd0);
            chk({tag, "_col"}, i, 32'(block_color_out[i]), 32'd0);
            chk({tag, "_dir"}, i, 32'(block_direction_out[i]), 32'd0);
        end
    endtask

    vec_t v;

    initial begin
        // Reset with nonzero inputs on the ports
        v = rand_vec();
        v.bt = '1;
        curr_time_in = v.t; block_x_in = v.x; block_y_in = v.y; block_time_in = v.bt;
        block_color_in = '1; block_direction_in = v.d; block_visible_in = '1;
        repeat (3) @(posedge clk_in);
        #1;
        check_all_zero("reset");
        @(negedge clk_in);
        rst_in = 1'b1;

        // Approach: slot 0 hits at t=150, time advancing by 5
        v = base_vec();
        v.x[0] = 12'd200; v.y[0] = 12'd200; v.bt[0] = 18'd150;
        for (int t = 0; t <= 160; t += 5) begin
            v.t = TIME_W'(t);
            step(v);
        end

        // Hold t=0 so the approach start value is observable directly
        v.t = '0;
        repeat (3) step(v);
        chk("approach_z600", 0, 32'(block_z_out[0]), 32'd600);
        chk("approach_vis",  0, 32'(block_visible_out[0]), 32'd1);
        chk("approach_x",    0, 32'(block_x_out[0]), 32'd200);

        v.t = 18'd150;
        repeat (3) step(v);
        chk("hit_z", 0, 32'(block_z_out[0]), 32'd0);
        chk("hit_vis", 0, 32'(block_visible_out[0]), 32'd1);
        v.t = 18'd151;
        repeat (3) step(v);
        chk("late_vis", 0, 32'(block_visible_out[0]), 32'd0);

        // Far cull boundary
        v.t = '0; v.bt[0] = 18'd4000; v.bt[1] = 18'd4001; v.bt[2] = 18'd0;
        repeat (3) step(v);
        chk("far_z",     0, 32'(block_z_out[0]), 32'd16000);
        chk("far_vis",   0, 32'(block_visible_out[0]), 32'd1);
        chk("cull_z",    1, 32'(block_z_out[1]), 32'd16004);
        chk("cull_vis",  1, 32'(block_visible_out[1]), 32'd0);
        chk("zero_vis",  2, 32'(block_visible_out[2]), 32'd1);
        v.bt[3] = 18'd5000;
        repeat (3) step(v);
        chk("sat_z",     3, 32'(block_z_out[3]), 32'd16383);

        // Independence across slots
        v = rand_vec();
        v.t = 18'd50; v.m = '1;
        for (int i = 0; i < int'(N); i++) v.bt[i] = TIME_W'(i * 10);
        repeat (3) step(v);
        chk("ind_vis4",  4, 32'(block_visible_out[4]), 32'd0);
        chk("ind_z5",    5, 32'(block_z_out[5]), 32'd0);
        chk("ind_vis5",  5, 32'(block_visible_out[5]), 32'd1);
        chk("ind_z11",  11, 32'(block_z_out[11]), 32'd240);

`ifdef BLOCK_VISIBLE_MASK_EN
        v = base_vec();
        v.bt[0] = 18'd150; v.m[0] = 1'b0;
        repeat (3) step(v);
        chk("mask_vis", 0, 32'(block_visible_out[0]), 32'd0);
        chk("mask_z",   0, 32'(block_z_out[0]), 32'd600);
`endif

        // Randomized traffic
        for (int k = 0; k < 200; k++) step(rand_vec());

        // Mid-operation reset clears everything; refill afterwards
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        check_all_zero("midreset");
        pend.delete();
        @(negedge clk_in);
        rst_in = 1'b1;
        for (int k = 0; k < 60; k++) step(rand_vec());

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Hard bound on runtime
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
